// File: rtl/store_unit_pkg.sv
// Shared MEM-stage types, bus address windows and the window-check helper.
package store_unit_pkg;

  typedef enum logic [3:0] {
    OP_NOP, OP_ALU, OP_LW, OP_LH, OP_LB, OP_SW, OP_SH, OP_SB
  } opcode_t;

  typedef struct packed {
    opcode_t    opcode;
    logic [4:0] wb_addr;
    logic       wb_en;
  } wbsignal_t;

  typedef struct packed {
    logic [29:0] waddr;
    logic [31:0] data;
    logic [3:0]  be;
  } store_entry_t;

  localparam logic [31:0] START_ADDR_DM  = 32'h0000_0000;
  localparam logic [31:0] END_ADDR_DM    = 32'h0000_2FFF;
  localparam logic [31:0] START_ADDR_INS = 32'h0000_3000;
  localparam logic [31:0] END_ADDR_INS   = 32'h0000_6FFF;
  localparam logic [31:0] START_ADDR_TC0 = 32'h0000_7F00;
  localparam logic [31:0] END_ADDR_TC0   = 32'h0000_7F0B;
  localparam logic [31:0] START_ADDR_TC1 = 32'h0000_7F10;
  localparam logic [31:0] END_ADDR_TC1   = 32'h0000_7F1B;

  function automatic logic in_window(input logic [31:0] a, input logic [31:0] lo,
                                     input logic [31:0] hi);
    return (a >= lo) && (a <= hi);
  endfunction

endpackage

// File: rtl/store_fifo.sv
// Synchronous store-buffer FIFO with an all-entries view for load address matching.
// Pushed entry visible at head next cycle; push ignored when full, pop ignored when empty.
module store_fifo
  import store_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push_i,
  input  logic                      pop_i,
  input  store_entry_t              din_i,
  output logic                      full_o,
  output logic                      empty_o,
  output store_entry_t              head_o,
  output store_entry_t [DEPTH-1:0]  entries_o,
  output logic [DEPTH-1:0]          valid_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  store_entry_t       mem_q [DEPTH];
  logic [PTR_W-1:0]   wptr_q, rptr_q;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               do_push, do_pop;
  logic [PTR_W-1:0]   offs;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem_q[rptr_q];

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PTR_W'(1);
      if (do_pop)  rptr_q <= rptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  // Payload storage needs no reset: validity comes from the pointers and count.
  always_ff @(posedge clk) begin
    if (do_push && !reset) mem_q[wptr_q] <= din_i;
  end

  always_comb begin
    offs      = '0;
    entries_o = '0;
    valid_o   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entries_o[i] = mem_q[i];
      offs         = PTR_W'(i) - rptr_q;
      valid_o[i]   = ({1'b0, offs} < count_q);
    end
  end

endmodule

// File: rtl/store_unit.sv
// MEM-stage store path: sw/sh/sb encode, AdES detection, store buffer draining to the bus.
// Enqueued store reaches the bus the next cycle; stalls MEM while the buffer is full.
module store_unit
  import store_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  wbsignal_t   wbSignal_MEM,
  input  logic [31:0] Addr,
  input  logic [31:0] Wdata,
  input  logic        overflow,
  input  logic [31:0] ld_addr,
  output logic        excAdES,
  output logic        stall,
  output logic        ld_hit,
  output logic        bus_valid,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ready
);

  logic is_sw, is_sh, is_sb, is_store;
  logic in_dm, in_tc0, in_tc1, in_tc;
  logic align_err, range_err, timer_err;
  logic [3:0]  st_be;
  logic [31:0] st_data;
  logic push, pop, full, empty;
  store_entry_t             head, din;
  store_entry_t [DEPTH-1:0] entries;
  logic [DEPTH-1:0]         valid;
  logic unused_sig;

  assign unused_sig = ^{wbSignal_MEM.wb_addr, wbSignal_MEM.wb_en, ld_addr[1:0]};

  assign is_sw    = (wbSignal_MEM.opcode == OP_SW);
  assign is_sh    = (wbSignal_MEM.opcode == OP_SH);
  assign is_sb    = (wbSignal_MEM.opcode == OP_SB);
  assign is_store = req_valid & (is_sw | is_sh | is_sb);

  always_comb begin
    st_be   = 4'b1111;
    st_data = Wdata;
    if (is_sh) begin
      st_be   = Addr[1] ? 4'b1100 : 4'b0011;
      st_data = {2{Wdata[15:0]}};
    end else if (is_sb) begin
      st_be   = 4'b0001 << Addr[1:0];
      st_data = {4{Wdata[7:0]}};
    end
  end

  assign in_dm  = in_window(Addr, START_ADDR_DM, END_ADDR_DM);
  assign in_tc0 = in_window(Addr, START_ADDR_TC0, END_ADDR_TC0);
  assign in_tc1 = in_window(Addr, START_ADDR_TC1, END_ADDR_TC1);
  assign in_tc  = in_tc0 | in_tc1;

  // Timers only take full-word writes, and their Count register is read-only.
  assign align_err = (is_sw & (Addr[1:0] != 2'b00)) | (is_sh & Addr[0]);
  assign range_err = ~(in_dm | in_tc);
  assign timer_err = in_tc & (~is_sw | (Addr[3:2] == 2'b10));
  assign excAdES   = is_store & (align_err | range_err | timer_err | overflow);

  assign push  = is_store & ~excAdES & ~full;
  assign stall = is_store & ~excAdES & full;
  assign pop   = ~empty & bus_ready;
  assign din   = '{waddr: Addr[31:2], data: st_data, be: st_be};

  store_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push_i    (push),
    .pop_i     (pop),
    .din_i     (din),
    .full_o    (full),
    .empty_o   (empty),
    .head_o    (head),
    .entries_o (entries),
    .valid_o   (valid)
  );

  assign bus_valid = ~empty;
  assign bus_addr  = empty ? 32'h0 : {head.waddr, 2'b00};
  assign bus_wdata = empty ? 32'h0 : head.data;
  assign bus_be    = empty ? 4'h0  : head.be;

  always_comb begin
    ld_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && (entries[i].waddr == ld_addr[31:2])) ld_hit = 1'b1;
    end
  end

endmodule
